// File: rtl/str2num_parser_if.sv
// Character-memory bus and control/result signals of the string-to-number converter.
// master: software/memory side; slave: the converter.
interface str2num_parser_if #(
  parameter int W      = 16,
  parameter int ADDR_W = 8
) ();
  logic              Start;
  logic [ADDR_W-1:0] BaseAddr;
  logic              Hex;
  logic [7:0]        Char;
  logic [ADDR_W-1:0] Addr;
  logic              Ready;
  logic              Done;
  logic [W-1:0]      Num;
  logic              Err;
  logic              Ovf;

  // Start is a level request sampled in IDLE/INIT; Ready is high only while idle,
  // Done pulses for exactly one cycle when Num/Err/Ovf carry a fresh result.
  modport master (
    output Start, BaseAddr, Hex, Char,
    input  Addr, Ready, Done, Num, Err, Ovf
  );

  modport slave (
    input  Start, BaseAddr, Hex, Char,
    output Addr, Ready, Done, Num, Err, Ovf
  );
endinterface

// File: rtl/str2num_parser.sv
// Walks a NUL-terminated ASCII string one char per cycle and converts it to an
// integer (radix 10 or 16, optional sign, saturation on overflow). Assumes W >= 5.
module str2num_parser #(
  parameter int W       = 16,
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int SIGNED  = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  str2num_parser_if.slave   bus,
  output logic [2:0]        state_dbg_o
);

  localparam int AW = W + 5;
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] LIM_POS = (SIGNED != 0) ? ((ONE << (W - 1)) - ONE)
                                                    : ((ONE << W) - ONE);
  localparam logic [AW-1:0] LIM_NEG = (SIGNED != 0) ? (ONE << (W - 1)) : LIM_POS;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FIRST  = 3'd2,
    S_ACCUM  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]      acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              seen_q, seen_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              hex_q, hex_d;
  logic [W-1:0]      num_q, num_d;
  logic              err_o_q, err_o_d;
  logic              ovf_o_q, ovf_o_d;

  logic              dig_ok;
  logic [3:0]        dig_val;
  logic [AW-1:0]     acc_ext, prod, lim;
  logic              finish;

  // Digit decode uses the radix latched in INIT, not the live Hex input.
  always_comb begin
    dig_ok  = 1'b0;
    dig_val = 4'd0;
    if (bus.Char >= 8'h30 && bus.Char <= 8'h39) begin
      dig_ok  = 1'b1;
      dig_val = bus.Char[3:0];
    end else if (hex_q && ((bus.Char >= 8'h61 && bus.Char <= 8'h66) ||
                           (bus.Char >= 8'h41 && bus.Char <= 8'h46))) begin
      dig_ok  = 1'b1;
      dig_val = bus.Char[3:0] + 4'd9;
    end
  end

  assign acc_ext = AW'(acc_q);
  assign prod    = hex_q ? ((acc_ext << 4) + AW'(dig_val))
                         : ((acc_ext << 3) + (acc_ext << 1) + AW'(dig_val));
  assign lim     = neg_q ? LIM_NEG : LIM_POS;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    seen_d  = seen_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    num_d   = num_q;
    err_o_d = err_o_q;
    ovf_o_d = ovf_o_q;
    finish  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) state_d = S_INIT;
      end
      S_INIT: begin
        acc_d  = '0;
        neg_d  = 1'b0;
        cnt_d  = '0;
        seen_d = 1'b0;
        err_d  = 1'b0;
        ovf_d  = 1'b0;
        addr_d = bus.BaseAddr;
        hex_d  = bus.Hex;
        if (!bus.Start) state_d = S_FIRST;
      end
      S_FIRST: begin
        if ((SIGNED != 0) && bus.Char == CH_MINUS) begin
          neg_d   = 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = S_ACCUM;
        end else if ((SIGNED != 0) && bus.Char == CH_PLUS) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_ACCUM;
        end else if (dig_ok) begin
          acc_d   = W'(dig_val);
          seen_d  = 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = S_ACCUM;
        end else begin
          err_d  = 1'b1;
          finish = 1'b1;
        end
      end
      S_ACCUM: begin
        if (bus.Char == CH_NUL) begin
          err_d  = !seen_q;
          finish = 1'b1;
        end else if (cnt_q == ADDR_W'(MAX_LEN)) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else if (dig_ok) begin
          seen_d = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // After saturation acc stays pinned at the limit; syntax checking carries on.
          if (!ovf_q) begin
            if (prod > lim) begin
              ovf_d = 1'b1;
              acc_d = lim[W-1:0];
            end else begin
              acc_d = prod[W-1:0];
            end
          end
        end else begin
          err_d  = 1'b1;
          finish = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result registers load on the edge entering FINISH so they are valid with Done.
    if (finish) begin
      state_d = S_FINISH;
      if (err_d) begin
        num_d   = '0;
        err_o_d = 1'b1;
        ovf_o_d = 1'b0;
      end else begin
        num_d   = neg_d ? W'(-acc_d) : acc_d;
        err_o_d = 1'b0;
        ovf_o_d = ovf_d;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= 1'b0;
      num_q   <= '0;
      err_o_q <= 1'b0;
      ovf_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
      num_q   <= num_d;
      err_o_q <= err_o_d;
      ovf_o_q <= ovf_o_d;
    end
  end

  assign bus.Addr    = addr_q;
  assign bus.Ready   = (state_q == S_IDLE);
  assign bus.Done    = (state_q == S_FINISH);
  assign bus.Num     = num_q;
  assign bus.Err     = err_o_q;
  assign bus.Ovf     = ovf_o_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_str2num_parser.sv
// Bench for str2num_parser: three instances (signed/16, unsigned/16, signed/4) share one
// character memory and stimulus; results are compared against a string-level reference.
module tb_str2num_parser;
  localparam int W  = 16;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          hex       = 1'b0;
  logic [7:0]    mem [256];
  logic [2:0]    dbg0, dbg1, dbg2;

  str2num_parser_if #(.W(W), .ADDR_W(AW)) if0 ();
  str2num_parser_if #(.W(W), .ADDR_W(AW)) if1 ();
  str2num_parser_if #(.W(W), .ADDR_W(AW)) if2 ();

  assign if0.Start = start;  assign if0.BaseAddr = base_addr;  assign if0.Hex = hex;
  assign if1.Start = start;  assign if1.BaseAddr = base_addr;  assign if1.Hex = hex;
  assign if2.Start = start;  assign if2.BaseAddr = base_addr;  assign if2.Hex = hex;
  assign if0.Char = mem[if0.Addr];
  assign if1.Char = mem[if1.Addr];
  assign if2.Char = mem[if2.Addr];

  str2num_parser #(.W(W), .ADDR_W(AW), .MAX_LEN(16), .SIGNED(1)) u0 (
    .Clk(clk), .Rst_n(rst_n), .bus(if0), .state_dbg_o(dbg0));
  str2num_parser #(.W(W), .ADDR_W(AW), .MAX_LEN(16), .SIGNED(0)) u1 (
    .Clk(clk), .Rst_n(rst_n), .bus(if1), .state_dbg_o(dbg1));
  str2num_parser #(.W(W), .ADDR_W(AW), .MAX_LEN(4), .SIGNED(1)) u2 (
    .Clk(clk), .Rst_n(rst_n), .bus(if2), .state_dbg_o(dbg2));

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  byte         str_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int digit_of(input byte c, input logic hx);
    int v;
    v = int'(c);
    if (v >= 48 && v <= 57) return v - 48;
    if (hx && v >= 97 && v <= 102) return v - 87;
    if (hx && v >= 65 && v <= 70) return v - 55;
    return -1;
  endfunction

  task automatic model(input int sgn, input int maxlen, input logic hx, input logic [7:0] base,
                       output logic [W-1:0] num, output logic err, output logic ovf,
                       output logic [7:0] addr, output int lat);
    int     i, cnt, d;
    bit     neg, seen, stop;
    longint v, lim, mag;
    byte    c;
    i = 0; cnt = 0; neg = 0; seen = 0; v = 0; err = 0; stop = 0;
    c = str_b[0];
    d = digit_of(c, hx);
    if (sgn != 0 && (c == 8'h2D || c == 8'h2B)) begin
      neg = (c == 8'h2D);
      i = 1;
    end else if (d >= 0) begin
      v = d; seen = 1; i = 1;
    end else begin
      err = 1; stop = 1;
    end
    while (!stop) begin
      c = str_b[i];
      d = digit_of(c, hx);
      if (c == 0) begin
        err = !seen; stop = 1;
      end else if (cnt == maxlen) begin
        err = 1; stop = 1;
      end else if (d < 0) begin
        err = 1; stop = 1;
      end else begin
        v = v * (hx ? 16 : 10) + d;
        if (v > 64'd1099511627776) v = 64'd1099511627776;
        seen = 1; i++; cnt++;
      end
    end
    lim  = (sgn != 0) ? (neg ? 32768 : 32767) : 65535;
    ovf  = (v > lim);
    mag  = ovf ? lim : v;
    num  = neg ? W'(-mag) : W'(mag);
    if (err) begin
      num = '0;
      ovf = 1'b0;
    end
    addr = 8'(int'(base) + i);
    lat  = i + 1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_str(input string s);
    str_b.delete();
    for (int i = 0; i < s.len(); i++) str_b.push_back(s[i]);
    str_b.push_back(8'h00);
  endtask

  task automatic rand_str(input logic hx);
    string cs, bad;
    int    n;
    cs  = hx ? "0123456789abcdefABCDEF" : "0123456789";
    bad = "Gx z.";
    str_b.delete();
    n = $urandom_range(0, 19);
    if ($urandom_range(0, 4) == 0) str_b.push_back($urandom_range(0, 1) ? 8'h2D : 8'h2B);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 29) == 0) str_b.push_back(bad[$urandom_range(0, bad.len() - 1)]);
      else str_b.push_back(cs[$urandom_range(0, cs.len() - 1)]);
    end
    str_b.push_back(8'h00);
  endtask

  task automatic pulse_start(input logic hx, input logic [7:0] base, input int hold, input string name);
    for (int i = 0; i < str_b.size(); i++) mem[8'(int'(base) + i)] = str_b[i];
    @(negedge clk);
    start = 1'b1; base_addr = base; hex = hx;
    @(posedge clk);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      check({name, ".hold_ready"}, 32'(if0.Ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
  endtask

  task automatic run(input logic hx, input logic [7:0] base, input int hold, input string name);
    logic [W-1:0] en;  logic ee, eo;  logic [7:0] ea;  int el;
    int           dn[3], lat[3], rdy[3];
    logic         d[3], e[3], o[3], r[3];
    logic [W-1:0] n[3], fn[3];
    logic         fe[3], fo[3];
    logic [7:0]   a[3], fa[3];
    logic [31:0]  exp_num;
    for (int g = 0; g < 3; g++) begin
      model((g == 1) ? 0 : 1, (g == 2) ? 4 : 16, hx, base, en, ee, eo, ea, el);
      exp_q.push_back(32'(en)); exp_q.push_back(32'(ee)); exp_q.push_back(32'(eo));
      exp_q.push_back(32'(ea)); exp_q.push_back(32'(el));
      dn[g] = 0; lat[g] = 0; rdy[g] = 0; fn[g] = '0; fe[g] = 0; fo[g] = 0; fa[g] = '0;
    end
    pulse_start(hx, base, hold, name);
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      d[0] = if0.Done; n[0] = if0.Num; e[0] = if0.Err; o[0] = if0.Ovf; a[0] = if0.Addr; r[0] = if0.Ready;
      d[1] = if1.Done; n[1] = if1.Num; e[1] = if1.Err; o[1] = if1.Ovf; a[1] = if1.Addr; r[1] = if1.Ready;
      d[2] = if2.Done; n[2] = if2.Num; e[2] = if2.Err; o[2] = if2.Ovf; a[2] = if2.Addr; r[2] = if2.Ready;
      for (int g = 0; g < 3; g++) begin
        if (d[g]) begin
          dn[g]++;
          if (dn[g] == 1) begin
            lat[g] = c; fn[g] = n[g]; fe[g] = e[g]; fo[g] = o[g]; fa[g] = a[g];
          end
        end
        if (lat[g] != 0 && c == lat[g] + 1) rdy[g] = int'(r[g]);
      end
    end
    for (int g = 0; g < 3; g++) begin
      exp_num = exp_q.pop_front();
      check($sformatf("%s/u%0d.num", name, g), 32'(fn[g]), exp_num);
      check($sformatf("%s/u%0d.err", name, g), 32'(fe[g]), exp_q.pop_front());
      check($sformatf("%s/u%0d.ovf", name, g), 32'(fo[g]), exp_q.pop_front());
      check($sformatf("%s/u%0d.addr", name, g), 32'(fa[g]), exp_q.pop_front());
      check($sformatf("%s/u%0d.latency", name, g), 32'(lat[g]), exp_q.pop_front());
      check($sformatf("%s/u%0d.done_pulses", name, g), 32'(dn[g]), 32'd1);
      check($sformatf("%s/u%0d.ready_after", name, g), 32'(rdy[g]), 32'd1);
      check($sformatf("%s/u%0d.num_hold", name, g), 32'(n[g]), exp_num);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", 32'(if0.Ready), 32'd0 + 32'd1);
    check("reset.done", 32'(if0.Done), 32'd0);
    check("reset.num", 32'(if0.Num), 32'd0);
    check("reset.addr", 32'(if0.Addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset.ready", 32'(if0.Ready), 32'd1);

    set_str("123");                 run(1'b0, 8'h10, 1, "dec123");
    set_str("-32768");              run(1'b0, 8'h20, 1, "neg32768");
    set_str("32768");               run(1'b0, 8'h30, 1, "pos32768");
    set_str("-7fF");                run(1'b1, 8'h40, 1, "hex_m7ff");
    set_str("1G");                  run(1'b1, 8'h50, 1, "hex_1G");
    set_str("");                    run(1'b0, 8'h60, 1, "empty");
    set_str("-");                   run(1'b0, 8'h68, 1, "sign_only");
    set_str("-5");                  run(1'b0, 8'h70, 1, "minus5");
    set_str("123456");              run(1'b0, 8'h78, 3, "len6_hold3");
    set_str("+42");                 run(1'b0, 8'h88, 2, "plus42");
    set_str("FFFF");                run(1'b1, 8'h90, 1, "hex_ffff");
    set_str("00000000000000000065535"); run(1'b0, 8'hA0, 1, "too_long");
    set_str("999999999999");        run(1'b0, 8'hC0, 1, "sat_then_end");
    set_str("99999x");              run(1'b0, 8'hD0, 1, "sat_then_bad");

    for (int t = 0; t < 40; t++) begin
      logic hx;
      hx = 1'($urandom_range(0, 1));
      rand_str(hx);
      run(hx, 8'($urandom_range(0, 220)), $urandom_range(1, 3), $sformatf("rand%0d", t));
    end

    // Asynchronous reset in the middle of a conversion.
    set_str("32768");               run(1'b0, 8'h08, 1, "pre_reset");
    set_str("123456789");
    pulse_start(1'b0, 8'h18, 1, "abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset.ready", 32'(if0.Ready), 32'd1);
    check("mid_reset.done", 32'(if0.Done), 32'd0);
    check("mid_reset.num", 32'(if0.Num), 32'd0);
    check("mid_reset.ovf", 32'(if0.Ovf), 32'd0);
    check("mid_reset.addr", 32'(if0.Addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_str("42");                  run(1'b0, 8'h28, 1, "after_reset42");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
